// File: rtl/circle_point_gen_if.sv
// Point-generator bus: draw request, current boundary point with valid/ready
// handshake, and progress flags.
interface circle_point_gen_if;
  logic       start;
  logic [9:0] xc;
  logic [9:0] yc;
  logic [7:0] radius;
  logic [9:0] px;
  logic [9:0] py;
  logic       pvalid;
  logic       pready;
  logic       busy;
  logic       done;

  modport master (
    output start, xc, yc, radius, pready,
    input  px, py, pvalid, busy, done
  );

  modport slave (
    input  start, xc, yc, radius, pready,
    output px, py, pvalid, busy, done
  );
endinterface

// File: rtl/circle_point_gen.sv
// Midpoint circle rasteriser: walks one octant and emits the eight symmetric
// points per step, skipping off-screen candidates without a handshake.
module circle_point_gen #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic               clk,
  input  logic               reset,
  circle_point_gen_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic signed [11:0] H_LIM = 12'(H_RES);
  localparam logic signed [11:0] V_LIM = 12'(V_RES);

  logic [1:0]         state;
  logic [2:0]         idx;
  logic [9:0]         xc_r;
  logic [9:0]         yc_r;
  logic [7:0]         x;
  logic [7:0]         y;
  logic signed [10:0] err;

  logic signed [11:0] xc_s, yc_s, x_s, y_s;
  logic signed [11:0] cx, cy;
  logic               on_screen;
  logic signed [11:0] x_n, y_n, err_n;

  assign xc_s = {2'b00, xc_r};
  assign yc_s = {2'b00, yc_r};
  assign x_s  = {4'b0000, x};
  assign y_s  = {4'b0000, y};

  // Octant mirror for the current idx; kept 12-bit signed so off-screen
  // negatives and overflow past 1023 are both visible to the range check.
  always_comb begin
    cx = xc_s + x_s;
    cy = yc_s + y_s;
    case (idx)
      3'd0: begin cx = xc_s + x_s; cy = yc_s + y_s; end
      3'd1: begin cx = xc_s + y_s; cy = yc_s + x_s; end
      3'd2: begin cx = xc_s - y_s; cy = yc_s + x_s; end
      3'd3: begin cx = xc_s - x_s; cy = yc_s + y_s; end
      3'd4: begin cx = xc_s - x_s; cy = yc_s - y_s; end
      3'd5: begin cx = xc_s - y_s; cy = yc_s - x_s; end
      3'd6: begin cx = xc_s + y_s; cy = yc_s - x_s; end
      default: begin cx = xc_s + x_s; cy = yc_s - y_s; end
    endcase
  end

  assign on_screen = (cx >= 12'sd0) && (cx < H_LIM) &&
                     (cy >= 12'sd0) && (cy < V_LIM);

  // Midpoint step: y always advances, x only when the error is non-negative.
  always_comb begin
    y_n = y_s + 12'sd1;
    x_n = x_s;
    err_n = 12'(err) + (y_n <<< 1) + 12'sd1;
    if (err >= 11'sd0) begin
      x_n   = x_s - 12'sd1;
      err_n = 12'(err) + ((y_n - x_n) <<< 1) + 12'sd1;
    end
  end

  assign bus.px     = cx[9:0];
  assign bus.py     = cy[9:0];
  assign bus.pvalid = (state == EMIT) && on_screen;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);

  // NOTE: only control state is reset; the latched centre/radius and the
  // x/y/err walk are always loaded on start before they are used.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            xc_r  <= bus.xc;
            yc_r  <= bus.yc;
            x     <= bus.radius;
            y     <= 8'd0;
            err   <= 11'sd1 - $signed({3'b000, bus.radius});
            idx   <= 3'd0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (!on_screen || bus.pready) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STEP;
          end
        end
        STEP: begin
          x   <= x_n[7:0];
          y   <= y_n[7:0];
          err <= err_n[10:0];
          idx <= 3'd0;
          state <= (x_n < y_n) ? DONE : EMIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/circle_point_gen.md
CIRCLE_POINT_GEN -- requirements
Module: circle_point_gen

Interface
REQ-001 Parameter H_RES, default 640: horizontal screen size; a point is on-screen when 0 <= px < H_RES.
REQ-002 Parameter V_RES, default 480: vertical screen size; a point is on-screen when 0 <= py < V_RES.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to draw one circle; sampled only in IDLE.
REQ-006 xc  input  10  centre x, unsigned.
REQ-007 yc  input  10  centre y, unsigned.
REQ-008 radius  input  8  circle radius, unsigned, 0..255.
REQ-009 px  output  10  x coordinate of the current point.
REQ-010 py  output  10  y coordinate of the current point.
REQ-011 pvalid  output  1  px/py hold a valid on-screen boundary point.
REQ-012 pready  input  1  consumer accepts the point when pvalid && pready at a clock edge.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the circle is complete.

Function
REQ-015 The FSM SHALL have four states: IDLE, EMIT, STEP and DONE.
REQ-016 IDLE + start: latch xc, yc and radius; set x=radius, y=0, err=1-radius (signed, 11 bit), idx=0; go to EMIT.
- pvalid is first asserted on the cycle after start is sampled.
REQ-017 start while busy SHALL be ignored; the latched xc/yc/radius SHALL NOT change until the next IDLE.
REQ-018 EMIT: idx 0..7 SHALL select, in order:
- (xc+x,yc+y), (xc+y,yc+x), (xc-y,yc+x), (xc-x,yc+y)
- (xc-x,yc-y), (xc-y,yc-x), (xc+y,yc-x), (xc+x,yc-y)
REQ-019 Candidate sums SHALL be computed signed, 12 bit; no truncation before the on-screen check.
REQ-020 On-screen candidate: pvalid=1, with px/py equal to the low 10 bits.
- px, py and pvalid SHALL stay stable until the handshake.
- idx advances on the handshake.
REQ-021 Off-screen candidate: pvalid=0 and idx advances after exactly one cycle; no handshake occurs.
REQ-022 After idx 7 advances, go to STEP; symmetric duplicates (e.g. radius 0, y==0, x==y) SHALL NOT be removed.
REQ-023 STEP (one cycle, pvalid=0): y'=y+1.
- If err<0: x'=x and err'=err+2*y'+1.
- Otherwise: x'=x-1 and err'=err+2*(y'-x')+1.
REQ-024 STEP exit: if x'<y', go to DONE; otherwise go to EMIT with idx=0.
REQ-025 DONE SHALL last one cycle with done=1 and pvalid=0, then go to IDLE.
REQ-026 pvalid SHALL be low in IDLE, STEP and DONE; px/py are don't-care when pvalid=0.
REQ-027 pready while pvalid=0 SHALL have no effect.

Reset
REQ-028 On reset: state=IDLE, pvalid=0, busy=0, done=0, idx=0.
- reset asserted mid-circle SHALL abort it, with pvalid low on the next cycle and no done pulse.
REQ-029 reset SHALL take priority over start in the same cycle.

Verification
REQ-030 The bench SHALL cover:
- reset, start with xc=320, yc=240, radius=0, pready=1 -> 8 handshakes, each (320,240), then done one cycle later, busy low after that.
- radius=3 at (320,240), pready=1 -> 24 handshakes from (x,y) pairs (3,0), (3,1), (2,2) in REQ-018 order; first point (323,240); then done.
- same circle with pready toggling 1/0 every cycle -> identical point sequence; px/py stable while pvalid && !pready.
- radius=2 at (0,0) -> first point (2,0); no point with a negative coordinate is emitted; done asserted; every emitted point satisfies |x^2+y^2-4| <= 2.
- start pulsed during busy with different radius -> ignored; output matches the first request.
- reset asserted during the 5th point of radius=3 -> pvalid=0 next cycle, busy=0, no done; a fresh start reproduces the full 24-point sequence.
